// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational execute ALU among NUM_REQ
// requesters and captures each result in a single response slot tagged with its id.
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [4*NUM_REQ-1:0]  req_op,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [3:0]            alu_op,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    input  logic [31:0]           alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_result,
    output logic [ID_W-1:0]       rsp_id
);

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_result_q, rsp_result_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;

    logic               slot_free;
    logic               gnt_any;
    logic [ID_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0] gnt_oh;

    // The slot may be refilled in the same cycle the consumer drains it.
    assign slot_free = !rsp_valid_q || rsp_ready;

    // Round-robin pick: lowest valid index at or above ptr, else lowest valid overall.
    always_comb begin
        logic            found_hi;
        logic            found_any;
        logic [ID_W-1:0] idx_hi;
        logic [ID_W-1:0] idx_any;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        found_hi  = 1'b0;
        found_any = 1'b0;
        idx_hi    = '0;
        idx_any   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found_any = 1'b1;
                idx_any   = ID_W'(i);
                if (i >= int'(ptr_q)) begin
                    found_hi = 1'b1;
                    idx_hi   = ID_W'(i);
                end
            end
        end
        gnt_any = rst_n && slot_free && found_any;
        gnt_idx = found_hi ? idx_hi : idx_any;
    end

    always_comb begin
        gnt_oh = '0;
        alu_op = '0;
        alu_a  = '0;
        alu_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_any && (gnt_idx == ID_W'(i))) begin
                gnt_oh[i] = 1'b1;
                alu_op    = req_op[4*i +: 4];
                alu_a     = req_a[32*i +: 32];
                alu_b     = req_b[32*i +: 32];
            end
        end
    end

    assign req_ready = gnt_oh;

    always_comb begin
        ptr_d        = ptr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;
        if (gnt_any) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = alu_result;
            rsp_id_d     = gnt_idx;
            ptr_d        = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= '0;
        end else begin
            ptr_q        <= ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run
// against a cycle-level round-robin reference model; a 3-requester instance covers wrap.
module tb_alu_arbiter;

    localparam int N  = 2;
    localparam int N3 = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 2-requester instance
    logic [N-1:0]    req_valid;
    logic [3:0]      f_op [N];
    logic [31:0]     f_a  [N];
    logic [31:0]     f_b  [N];
    logic [4*N-1:0]  req_op;
    logic [32*N-1:0] req_a, req_b;
    logic [N-1:0]    req_ready;
    logic [3:0]      alu_op;
    logic [31:0]     alu_a, alu_b, alu_result;
    logic            rsp_valid, rsp_ready;
    logic [31:0]     rsp_result;
    logic [0:0]      rsp_id;

    // 3-requester instance
    logic [N3-1:0]    v3;
    logic [3:0]       f3_op [N3];
    logic [31:0]      f3_a  [N3];
    logic [31:0]      f3_b  [N3];
    logic [4*N3-1:0]  op3;
    logic [32*N3-1:0] a3, b3;
    logic [N3-1:0]    ready3;
    logic [3:0]       alu3_op;
    logic [31:0]      alu3_a, alu3_b, alu3_res;
    logic             rsp3_valid, rsp3_ready;
    logic [31:0]      rsp3_result;
    logic [1:0]       rsp3_id;

    int n_checks = 0;
    int n_pass   = 0;

    for (genvar g = 0; g < N; g++) begin : g_pack2
        assign req_op[4*g +: 4]  = f_op[g];
        assign req_a[32*g +: 32] = f_a[g];
        assign req_b[32*g +: 32] = f_b[g];
    end
    for (genvar g = 0; g < N3; g++) begin : g_pack3
        assign op3[4*g +: 4]  = f3_op[g];
        assign a3[32*g +: 32] = f3_a[g];
        assign b3[32*g +: 32] = f3_b[g];
    end

    // Environment ALU; codes above 7 are undefined and return 0.
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return 32'($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_a, alu_b);
    assign alu3_res   = alu_f(alu3_op, alu3_a, alu3_b);

    alu_arbiter #(.NUM_REQ(N), .ID_W(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_id(rsp_id)
    );

    alu_arbiter #(.NUM_REQ(N3), .ID_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v3), .req_op(op3), .req_a(a3), .req_b(b3),
        .req_ready(ready3),
        .alu_op(alu3_op), .alu_a(alu3_a), .alu_b(alu3_b), .alu_result(alu3_res),
        .rsp_valid(rsp3_valid), .rsp_ready(rsp3_ready),
        .rsp_result(rsp3_result), .rsp_id(rsp3_id)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 2'b11;
        for (int i = 0; i < N; i++) begin f_op[i] = 4'd3; f_a[i] = 32'hA5; f_b[i] = 32'h5A; end
        rsp_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_result !== 32'd0) $display("FAIL reset_rsp_result got=%h exp=0", rsp_result); else n_pass++;
        n_checks++; if (rsp_id !== 1'b0) $display("FAIL reset_rsp_id got=%h exp=0", rsp_id); else n_pass++;
        n_checks++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready got=%b exp=00", req_ready); else n_pass++;
        n_checks++; if ({alu_op, alu_a, alu_b} !== 68'd0) $display("FAIL reset_alu_zero got op=%h a=%h b=%h exp 0", alu_op, alu_a, alu_b); else n_pass++;
        n_checks++; if (ready3 !== 3'b000 || rsp3_valid !== 1'b0) $display("FAIL reset_dut3 got ready=%b vld=%b exp 000/0", ready3, rsp3_valid); else n_pass++;
        req_valid = '0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single;
        req_valid = 2'b01; f_op[0] = 4'd0; f_a[0] = 32'd5; f_b[0] = 32'd3; rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 2'b01) $display("FAIL single_ready got=%b exp=01", req_ready); else n_pass++;
        n_checks++; if (alu_op !== 4'd0 || alu_a !== 32'd5 || alu_b !== 32'd3) $display("FAIL single_alu got op=%h a=%h b=%h exp 0/5/3", alu_op, alu_a, alu_b); else n_pass++;
        tick();
        req_valid = 2'b00;
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); else n_pass++;
        n_checks++; if (rsp_result !== 32'd8) $display("FAIL single_rsp_result got=%h exp=8", rsp_result); else n_pass++;
        n_checks++; if (rsp_id !== 1'b0) $display("FAIL single_rsp_id got=%h exp=0", rsp_id); else n_pass++;
        tick();
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL single_drain got=%b exp=0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_result !== 32'd8) $display("FAIL single_hold_result got=%h exp=8", rsp_result); else n_pass++;
    endtask

    task automatic test_sra;
        // Pointer sits at 1 after requester 0 was served.
        req_valid = 2'b10; f_op[1] = 4'd7; f_a[1] = 32'h8000_0000; f_b[1] = 32'd4;
        #1;
        n_checks++; if (req_ready !== 2'b10) $display("FAIL sra_ready got=%b exp=10", req_ready); else n_pass++;
        tick();
        req_valid = 2'b00;
        n_checks++; if (rsp_result !== 32'hF800_0000) $display("FAIL sra_result got=%h exp=f8000000", rsp_result); else n_pass++;
        n_checks++; if (rsp_id !== 1'b1) $display("FAIL sra_id got=%h exp=1", rsp_id); else n_pass++;
        tick();
    endtask

    task automatic test_alternate;
        logic [31:0] exp_res;
        logic [0:0]  exp_id;
        req_valid = 2'b11; rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin f_op[i] = 4'($urandom_range(0, 7)); f_a[i] = $urandom; f_b[i] = $urandom; end
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_id = 1'(c % 2);
            n_checks++; if (req_ready !== (2'b01 << (c % 2))) $display("FAIL alt_ready[%0d] got=%b exp=%b", c, req_ready, 2'b01 << (c % 2)); else n_pass++;
            exp_res = alu_f(f_op[c % 2], f_a[c % 2], f_b[c % 2]);
            tick();
            n_checks++; if (rsp_id !== exp_id || rsp_result !== exp_res) $display("FAIL alt_rsp[%0d] got id=%h res=%h exp id=%h res=%h", c, rsp_id, rsp_result, exp_id, exp_res); else n_pass++;
            f_op[c % 2] = 4'($urandom_range(0, 7)); f_a[c % 2] = $urandom; f_b[c % 2] = $urandom;
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_backpressure;
        req_valid = 2'b01; f_op[0] = 4'd0; f_a[0] = 32'd1; f_b[0] = 32'd2; rsp_ready = 1'b0;
        #1;
        n_checks++; if (req_ready !== 2'b01) $display("FAIL bp_first_ready got=%b exp=01", req_ready); else n_pass++;
        tick();
        req_valid = 2'b10; f_op[1] = 4'd1; f_a[1] = 32'd100; f_b[1] = 32'd1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (req_ready !== 2'b00 || alu_a !== 32'd0) $display("FAIL bp_stall_ready[%0d] got=%b alu_a=%h exp 00/0", c, req_ready, alu_a); else n_pass++;
            tick();
            n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd3 || rsp_id !== 1'b0) $display("FAIL bp_stall_rsp[%0d] got vld=%b res=%h id=%h exp 1/3/0", c, rsp_valid, rsp_result, rsp_id); else n_pass++;
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 2'b10 || alu_a !== 32'd100) $display("FAIL bp_release_ready got=%b alu_a=%h exp 10/64", req_ready, alu_a); else n_pass++;
        tick();
        req_valid = 2'b00;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd99 || rsp_id !== 1'b1) $display("FAIL bp_release_rsp got vld=%b res=%h id=%h exp 1/63/1", rsp_valid, rsp_result, rsp_id); else n_pass++;
        tick();
    endtask

    task automatic test_reset_midflight;
        req_valid = 2'b01; f_op[0] = 4'd2; f_a[0] = 32'hF0; f_b[0] = 32'h3C; rsp_ready = 1'b0;
        tick();
        req_valid = 2'b00;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'h30) $display("FAIL mid_pre got vld=%b res=%h exp 1/30", rsp_valid, rsp_result); else n_pass++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_id !== 1'b0) $display("FAIL mid_reset got vld=%b res=%h id=%h exp 0/0/0", rsp_valid, rsp_result, rsp_id); else n_pass++;
        req_valid = 2'b11; rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 2'b01) $display("FAIL mid_ptr_cleared got=%b exp=01", req_ready); else n_pass++;
        tick();
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_three_req;
        rsp3_ready = 1'b1;
        for (int i = 0; i < N3; i++) begin f3_op[i] = 4'd0; f3_a[i] = 32'(10 * (i + 1)); f3_b[i] = 32'd1; end
        v3 = 3'b010;
        #1;
        n_checks++; if (ready3 !== 3'b010) $display("FAIL three_first got=%b exp=010", ready3); else n_pass++;
        tick();
        v3 = 3'b001;
        #1;
        n_checks++; if (ready3 !== 3'b001) $display("FAIL three_wrap_ready got=%b exp=001", ready3); else n_pass++;
        tick();
        n_checks++; if (rsp3_id !== 2'd0 || rsp3_result !== 32'd11) $display("FAIL three_wrap_rsp got id=%h res=%h exp 0/b", rsp3_id, rsp3_result); else n_pass++;
        v3 = 3'b111;
        #1;
        n_checks++; if (ready3 !== 3'b010) $display("FAIL three_ptr_after_wrap got=%b exp=010", ready3); else n_pass++;
        tick();
        v3 = 3'b000;
        tick();
    endtask

    task automatic test_random;
        int          m_ptr;
        logic        m_vld;
        logic [31:0] m_res;
        int          m_id;
        int          g;
        logic [N-1:0] exp_rdy;
        logic [3:0]  e_op;
        logic [31:0] e_a, e_b;
        req_valid = '0; rsp_ready = 1'b1;
        do_reset();
        m_ptr = 0; m_vld = 1'b0; m_res = '0; m_id = 0;
        exp_rdy = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            // A pending request is held until accepted; others may change freely.
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || exp_rdy[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    f_op[i] = 4'($urandom_range(0, 15));
                    f_a[i] = $urandom;
                    f_b[i] = $urandom;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = -1;
            if (!m_vld || rsp_ready)
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            exp_rdy = '0; e_op = '0; e_a = '0; e_b = '0;
            if (g >= 0) begin
                exp_rdy[g] = 1'b1; e_op = f_op[g]; e_a = f_a[g]; e_b = f_b[g];
            end
            n_checks++; if (req_ready !== exp_rdy) $display("FAIL rnd_ready[%0d] got=%b exp=%b", cyc, req_ready, exp_rdy); else n_pass++;
            n_checks++; if (alu_op !== e_op || alu_a !== e_a || alu_b !== e_b) $display("FAIL rnd_alu[%0d] got %h/%h/%h exp %h/%h/%h", cyc, alu_op, alu_a, alu_b, e_op, e_a, e_b); else n_pass++;
            tick();
            if (g >= 0) begin
                m_res = alu_f(f_op[g], f_a[g], f_b[g]); m_id = g; m_vld = 1'b1; m_ptr = (g + 1) % N;
            end else if (m_vld && rsp_ready) begin
                m_vld = 1'b0;
            end
            n_checks++; if (rsp_valid !== m_vld) $display("FAIL rnd_rsp_valid[%0d] got=%b exp=%b", cyc, rsp_valid, m_vld); else n_pass++;
            n_checks++; if (rsp_result !== m_res || rsp_id !== 1'(m_id)) $display("FAIL rnd_rsp[%0d] got res=%h id=%h exp res=%h id=%0d", cyc, rsp_result, rsp_id, m_res, m_id); else n_pass++;
        end
        req_valid = '0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b1; v3 = '0; rsp3_ready = 1'b1;
        for (int i = 0; i < N; i++) begin f_op[i] = '0; f_a[i] = '0; f_b[i] = '0; end
        for (int i = 0; i < N3; i++) begin f3_op[i] = '0; f3_a[i] = '0; f3_b[i] = '0; end
        tick();
        test_reset();
        test_single();
        test_sra();
        test_alternate();
        test_backpressure();
        test_reset_midflight();
        test_three_req();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
